stream_enable_ctrl: RTL and testbench

Stream-to-enable adapter that sits directly upstream of the enable-gated census/window delay pipeline. It converts a valid/ready pixel stream into the single `CLK_en` that advances every pipeline stage. It carries valid/last/user tags alongside the pipeline so the pipeline output is re-emitted as a valid/ready stream. At end of line it injects padding beats so the final real pixels drain out of the pipeline.

---
 rtl/sncntx_pkg.sv | 32 +++
 rtl/en_tag_pipe.sv | 39 +++
 rtl/stream_enable_ctrl.sv | 138 +++++++++++++
 tb/tb_stream_enable_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sncntx_pkg.sv
// rtl/sncntx_pkg.sv - shared types for the stream-to-enable adapter
//
// Purpose : tag carried alongside the enable-gated pixel pipeline and
//           the adapter FSM state encoding.
// Contents: tag_t      packed {valid, last, user}
//           state_t    RUN / PAD
//           TAG_NONE   empty tag (pad beats, cleared stages)
//           make_tag() builds a tag from its three fields
package sncntx_pkg;

  typedef struct packed {
    logic valid;
    logic last;
    logic user;
  } tag_t;

  typedef enum logic {
    RUN = 1'b0,
    PAD = 1'b1
  } state_t;

  localparam tag_t TAG_NONE = '0;

  function automatic tag_t make_tag(input logic valid, input logic last, input logic user);
    tag_t t;
    t.valid = valid;
    t.last  = last;
    t.user  = user;
    return t;
  endfunction

endpackage

// File: rtl/en_tag_pipe.sv
// rtl/en_tag_pipe.sv - enable-gated shift register of pipeline tags
//
// Purpose : mirrors the external pixel pipeline one stage per CLK_en so
//           the tag leaving the last stage lines up with pipe_q.
// Ports   : CLK_in   clock
//           RSTn_in  asynchronous active-low clear of every stage
//           CLK_en   advance strobe (same one the pixel pipeline uses)
//           tag_d    tag entering stage 0
//           tag_q    tag held in the last stage
module en_tag_pipe
  import sncntx_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic CLK_in,
  input  logic RSTn_in,
  input  logic CLK_en,
  input  tag_t tag_d,
  output tag_t tag_q
);

  tag_t stages [LATENCY];

  always_ff @(posedge CLK_in or negedge RSTn_in) begin
    if (!RSTn_in) begin
      for (int i = 0; i < LATENCY; i++) begin
        stages[i] <= TAG_NONE;
      end
    end else if (CLK_en) begin
      stages[0] <= tag_d;
      for (int i = 1; i < LATENCY; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_q = stages[LATENCY-1];

endmodule

// File: rtl/stream_enable_ctrl.sv
// rtl/stream_enable_ctrl.sv - valid/ready stream to pipeline enable adapter
//
// Purpose : drives the single CLK_en of an enable-gated delay pipeline
//           from a valid/ready pixel stream, re-emits the pipeline output
//           as a valid/ready stream, and injects PAD_BEATS padding beats
//           after every end-of-line so the last real pixels drain out.
// Ports   : CLK_in, RSTn_in        clock, asynchronous active-low reset
//           s_valid/s_ready        input handshake
//           s_data/s_last/s_user   input pixel, end-of-line, start-of-frame
//           CLK_en                 advance strobe for every pipeline stage
//           pipe_d                 pixel into pipeline stage 0
//           pipe_q                 pixel out of the last pipeline stage
//           m_valid/m_ready        output handshake
//           m_data/m_last/m_user   output pixel and tags aligned to it
module stream_enable_ctrl
  import sncntx_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LATENCY   = 4,
  parameter int               PAD_BEATS = 4,
  parameter logic [WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic             CLK_in,
  input  logic             RSTn_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  input  logic             s_user,
  output logic             CLK_en,
  output logic [WIDTH-1:0] pipe_d,
  input  logic [WIDTH-1:0] pipe_q,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             m_user
);

  // Counter must hold 0..PAD_BEATS-1; keep at least one bit when padding is off.
  localparam int             CNT_W    = (PAD_BEATS > 0) ? $clog2(PAD_BEATS + 1) : 1;
  localparam bit             PAD_EN   = (PAD_BEATS > 0);
  localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'((PAD_BEATS > 0) ? PAD_BEATS - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] pad_cnt_q, pad_cnt_d;
  logic             taken_q;
  tag_t             tag_in;
  tag_t             tail;
  logic             free;
  logic             en_raw;
  logic             s_ready_raw;

  // Output slot is free when nothing is presented or it leaves this cycle.
  assign free = !m_valid | m_ready;

  always_comb begin
    state_d     = state_q;
    pad_cnt_d   = pad_cnt_q;
    s_ready_raw = 1'b0;
    en_raw      = 1'b0;
    pipe_d      = s_data;
    tag_in      = TAG_NONE;

    case (state_q)
      RUN: begin
        s_ready_raw = free;
        en_raw      = s_valid & free;
        tag_in      = make_tag(1'b1, s_last, s_user);
        if (en_raw && s_last && PAD_EN) begin
          state_d   = PAD;
          pad_cnt_d = '0;
        end
      end

      PAD: begin
        // Pad beats advance whenever the output can move; no input needed.
        en_raw = free;
        pipe_d = PAD_VALUE;
        if (en_raw) begin
          if (pad_cnt_q == PAD_LAST) begin
            state_d   = RUN;
            pad_cnt_d = '0;
          end else begin
            pad_cnt_d = pad_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d   = RUN;
        pad_cnt_d = '0;
      end
    endcase
  end

  // Reset forces the handshake outputs low immediately, not at the next edge.
  assign s_ready = s_ready_raw & RSTn_in;
  assign CLK_en  = en_raw & RSTn_in;

  always_ff @(posedge CLK_in or negedge RSTn_in) begin
    if (!RSTn_in) begin
      state_q   <= RUN;
      pad_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pad_cnt_q <= pad_cnt_d;
    end
  end

  // taken marks a tail beat already handed downstream while the pipeline is
  // held; the next advance replaces the tail and re-arms the output.
  always_ff @(posedge CLK_in or negedge RSTn_in) begin
    if (!RSTn_in) begin
      taken_q <= 1'b0;
    end else if (CLK_en) begin
      taken_q <= 1'b0;
    end else if (m_valid && m_ready) begin
      taken_q <= 1'b1;
    end
  end

  en_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .CLK_in  (CLK_in),
    .RSTn_in (RSTn_in),
    .CLK_en  (CLK_en),
    .tag_d   (tag_in),
    .tag_q   (tail)
  );

  assign m_valid = tail.valid & !taken_q;
  assign m_last  = tail.last & m_valid;
  assign m_user  = tail.user & m_valid;
  assign m_data  = pipe_q;

endmodule

// File: tb/tb_stream_enable_ctrl.sv
// tb/tb_stream_enable_ctrl.sv - self-checking bench for stream_enable_ctrl
module tb_stream_enable_ctrl;

  localparam int LAT  = 4;
  localparam int PADN = 4;
  localparam logic [7:0] PADV = 8'hA5;
  localparam logic [7:0] XF   = 8'h5A;

  logic       clk;
  logic       rst_n;
  logic       s_valid, s_last, s_user, m_ready;
  logic [7:0] s_data;

  logic       s_ready1, en1, m_valid1, m_last1, m_user1;
  logic [7:0] pipe_d1, pipe_q1, m_data1;
  logic       s_ready2, en2, m_valid2, m_last2, m_user2;
  logic [7:0] pipe_d2, pipe_q2, m_data2;

  logic [7:0] env1 [LAT];
  logic [7:0] env2 [LAT];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         is_beat;
    logic [7:0] data;
    bit         last;
    bit         user;
  } ent_t;

  ent_t hist [8192];
  int   en_count;
  int   pad_left;
  int   emitted;

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       sl;
    logic       su;
    logic       mr;
    logic       e_sr;
    logic       e_en;
    logic       e_mv;
    logic       e_ml;
    logic       e_mu;
    logic [7:0] e_md;
  } vec_t;

  vec_t tbl [13];

  stream_enable_ctrl #(
    .WIDTH(8), .LATENCY(LAT), .PAD_BEATS(PADN), .PAD_VALUE(PADV)
  ) dut (
    .CLK_in(clk), .RSTn_in(rst_n),
    .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data), .s_last(s_last), .s_user(s_user),
    .CLK_en(en1), .pipe_d(pipe_d1), .pipe_q(pipe_q1),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_last(m_last1), .m_user(m_user1)
  );

  stream_enable_ctrl #(
    .WIDTH(8), .LATENCY(LAT), .PAD_BEATS(0), .PAD_VALUE(8'h00)
  ) dut_nopad (
    .CLK_in(clk), .RSTn_in(rst_n),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data), .s_last(s_last), .s_user(s_user),
    .CLK_en(en2), .pipe_d(pipe_d2), .pipe_q(pipe_q2),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_last(m_last2), .m_user(m_user2)
  );

  // External delay pipeline: a transform so m_data differs from the input pixel.
  always @(posedge clk) begin
    if (en1) begin
      env1[0] <= pipe_d1 ^ XF;
      for (int i = 1; i < LAT; i++) env1[i] <= env1[i-1];
    end
    if (en2) begin
      env2[0] <= pipe_d2 ^ XF;
      for (int i = 1; i < LAT; i++) env2[i] <= env2[i-1];
    end
  end
  assign pipe_q1 = env1[LAT-1];
  assign pipe_q2 = env2[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    en_count = 0;
    pad_left = 0;
    emitted  = -1;
  endtask

  // Reference: every enable appends one entry; the entry LAT enables old is
  // what sits at the output, shown once unless already handed over.
  task automatic do_cycle(input logic sv, input logic [7:0] sd, input logic sl,
                          input logic su, input logic mr);
    int   t;
    bit   mv, free, pad, esr, een;
    logic [7:0] epd;
    @(negedge clk);
    s_valid = sv; s_data = sd; s_last = sl; s_user = su; m_ready = mr;
    #1;
    t    = en_count - LAT;
    mv   = (t >= 0) && hist[t].is_beat && (emitted != t);
    free = !mv || mr;
    pad  = (pad_left > 0);
    esr  = !pad && free;
    een  = pad ? free : (sv && free);
    epd  = pad ? PADV : sd;
    chk("s_ready", s_ready1, esr);
    chk("clk_en", en1, een);
    chk("pipe_d", pipe_d1, epd);
    chk("m_valid", m_valid1, mv);
    if (mv) begin
      chk("m_data", m_data1, hist[t].data ^ XF);
      chk("m_last", m_last1, hist[t].last);
      chk("m_user", m_user1, hist[t].user);
    end else begin
      chk("m_last_idle", m_last1, 1'b0);
      chk("m_user_idle", m_user1, 1'b0);
    end
    if (mv && mr) emitted = t;
    if (een && en_count < 8192) begin
      if (pad) begin
        hist[en_count] = '{is_beat: 1'b0, data: PADV, last: 1'b0, user: 1'b0};
        pad_left--;
      end else begin
        hist[en_count] = '{is_beat: 1'b1, data: sd, last: sl, user: su};
        if (sl && PADN > 0) pad_left = PADN;
      end
      en_count++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0; s_user = 1'b0; m_ready = 1'b1;
    #1;
    chk("rst_s_ready", s_ready1, 1'b0);
    chk("rst_clk_en", en1, 1'b0);
    chk("rst_m_valid", m_valid1, 1'b0);
    chk("rst_m_last", m_last1, 1'b0);
    chk("rst_m_user", m_user1, 1'b0);
    chk("rst_pipe_d", pipe_d1, 8'h3C);
    model_reset();
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    s_valid = 0; s_data = 0; s_last = 0; s_user = 0; m_ready = 0;
    model_reset();

    // Basic flow: 8 beats, last on beat 8, then 4 pad cycles.
    for (int c = 0; c < 13; c++) begin
      tbl[c].sv   = (c < 12);
      tbl[c].sd   = (c < 8) ? 8'(c + 1) : 8'd9;
      tbl[c].sl   = (c == 7);
      tbl[c].su   = (c == 0);
      tbl[c].mr   = 1'b1;
      tbl[c].e_sr = (c < 8) || (c == 12);
      tbl[c].e_en = (c < 12);
      tbl[c].e_mv = (c >= 4) && (c < 12);
      tbl[c].e_ml = (c == 11);
      tbl[c].e_mu = (c == 4);
      tbl[c].e_md = 8'(c - 3) ^ XF;
    end

    apply_reset();
    for (int c = 0; c < 13; c++) begin
      do_cycle(tbl[c].sv, tbl[c].sd, tbl[c].sl, tbl[c].su, tbl[c].mr);
      chk("tbl_s_ready", s_ready1, tbl[c].e_sr);
      chk("tbl_clk_en", en1, tbl[c].e_en);
      chk("tbl_m_valid", m_valid1, tbl[c].e_mv);
      chk("tbl_m_last", m_last1, tbl[c].e_ml);
      chk("tbl_m_user", m_user1, tbl[c].e_mu);
      if (tbl[c].e_mv) chk("tbl_m_data", m_data1, tbl[c].e_md);
    end

    // Input gaps: enable follows s_valid only.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_cycle((i == 0 || i == 3), 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
      chk("gap_clk_en", en1, (i == 0 || i == 3));
    end
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Backpressure then consume without enable.
    apply_reset();
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      chk("bp_clk_en", en1, 1'b0);
      chk("bp_s_ready", s_ready1, 1'b0);
      chk("bp_m_valid", m_valid1, 1'b1);
      chk("bp_m_data", m_data1, 8'h10 ^ XF);
    end
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("consume_m_valid", m_valid1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("after_consume_m_valid", m_valid1, 1'b0);
    end
    do_cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
    chk("resume_clk_en", en1, 1'b1);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("resume_m_valid", m_valid1, 1'b1);
    chk("resume_m_data", m_data1, 8'h11 ^ XF);

    // Frame start with padding disabled (second instance).
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      do_cycle(1'b1, 8'(i + 1), (i == 2), (i == 0), 1'b1);
      chk("np_s_ready", s_ready2, 1'b1);
      chk("np_m_valid", m_valid2, (i >= 4));
      chk("np_m_user", m_user2, (i == 4));
      chk("np_m_last", m_last2, (i == 6));
      if (i >= 4) chk("np_m_data", m_data2, 8'(i - 3) ^ XF);
    end

    // Reset during pad beat 2.
    apply_reset();
    do_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'h66; m_ready = 1'b1;
    #1;
    chk("pad2_clk_en", en1, 1'b1);
    chk("pad2_s_ready", s_ready1, 1'b0);
    chk("pad2_pipe_d", pipe_d1, PADV);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midpad_rst_s_ready", s_ready1, 1'b0);
    chk("midpad_rst_clk_en", en1, 1'b0);
    chk("midpad_rst_m_valid", m_valid1, 1'b0);
    chk("midpad_rst_m_last", m_last1, 1'b0);
    chk("midpad_rst_m_user", m_user1, 1'b0);
    model_reset();
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_s_ready", s_ready1, 1'b1);
    chk("post_rst_m_valid", m_valid1, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the reference model.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      do_cycle(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
